// File: rtl/pulse_sync_sched.sv
// pulse_sync_sched: source-domain scheduler in front of a toggle-based
// fast-to-slow pulse synchronizer. Counts per-requester events, grants them
// round-robin and issues one s_pluse at a time, spaced GAP src_clk cycles apart.
// Optional build macro: PSCHED_PRIO0_EN gives requester 0 strict priority.
module pulse_sync_sched #(
  parameter int N_REQ = 4,
  parameter int GAP   = 6,
  parameter int CNT_W = 4,
  parameter int IDW   = 2
) (
  input  logic             src_clk,
  input  logic             src_rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] ovf_clr,
  output logic             s_pluse,
  output logic [IDW-1:0]   s_id,
  output logic             pend_any,
  output logic [N_REQ-1:0] ovf
);

  // Gap counter only has to hold GAP-2; GAP=2 still needs one bit.
  localparam int GW = (GAP > 2) ? $clog2(GAP - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, FIRE, HOLD} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [GW-1:0]        gap_cnt;
  logic [GW-1:0]        gap_nxt;
  logic [CNT_W-1:0]     cnt     [N_REQ];
  logic [CNT_W-1:0]     cnt_nxt [N_REQ];
  logic [N_REQ-1:0]     ovf_set;
  logic [N_REQ-1:0]     nz;
  logic                 any_pend;
  logic [IDW-1:0]       rr_ptr;
  logic [IDW-1:0]       win_id;
  logic                 rr_upd;
  logic                 grant;
  logic [N_REQ-1:0]     grant_vec;
  logic [2*N_REQ-1:0]   rot;
  int                   win_off;

  // Flag which requesters have work pending in the registered counters.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      nz[i] = (cnt[i] != '0);
    end
    any_pend = |nz;
  end

  // Round-robin pick: rotate the pending vector so bit 0 is the slot after rr_ptr.
  always_comb begin
    rot     = {nz, nz} >> (int'(rr_ptr) + 1);
    win_off = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        win_off = k;
      end
    end
    win_id = IDW'((int'(rr_ptr) + 1 + win_off) % N_REQ);
    rr_upd = 1'b1;
`ifdef PSCHED_PRIO0_EN
    if (nz[0]) begin
      win_id = '0;
      rr_upd = 1'b0;
    end
`endif
  end

  // Scheduler FSM: a grant happens on every edge that enters FIRE.
  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_cnt;
    grant     = 1'b0;
    case (state)
      IDLE: begin
        if (en && any_pend) begin
          state_nxt = FIRE;
          grant     = 1'b1;
        end
      end
      FIRE: begin
        state_nxt = HOLD;
        gap_nxt   = GW'(GAP - 2);
      end
      HOLD: begin
        if (gap_cnt == '0) begin
          if (en && any_pend) begin
            state_nxt = FIRE;
            grant     = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          gap_nxt = gap_cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One-hot view of the grant for the counter update.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      grant_vec[i] = grant && (win_id == IDW'(i));
    end
  end

  // Per-requester counters: new event and grant in the same edge cancel out.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      cnt_nxt[i] = cnt[i];
      ovf_set[i] = 1'b0;
      if (req[i] && !grant_vec[i]) begin
        if (cnt[i] == CNT_MAX) begin
          ovf_set[i] = 1'b1;
        end else begin
          cnt_nxt[i] = cnt[i] + 1'b1;
        end
      end else if (!req[i] && grant_vec[i]) begin
        cnt_nxt[i] = cnt[i] - 1'b1;
      end
    end
  end

  // State, counters, sticky overflow and the held index; pend_any lags the counters by one cycle.
  always_ff @(posedge src_clk or posedge src_rst) begin
    if (src_rst) begin
      state    <= IDLE;
      gap_cnt  <= '0;
      rr_ptr   <= IDW'(N_REQ - 1);
      s_id     <= '0;
      pend_any <= 1'b0;
      ovf      <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      state    <= state_nxt;
      gap_cnt  <= gap_nxt;
      pend_any <= any_pend;
      ovf      <= (ovf & ~ovf_clr) | ovf_set;
      for (int i = 0; i < N_REQ; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
      if (grant) begin
        s_id <= win_id;
        if (rr_upd) begin
          rr_ptr <= win_id;
        end
      end
    end
  end

  assign s_pluse = (state == FIRE);

endmodule

// File: tb/tb_pulse_sync_sched.sv
// tb_pulse_sync_sched: directed scenarios with a pulse scoreboard; the
// monitor pops one expected (cycle, id) entry per observed s_pluse.
// Cycle k spans posedge at time 10k+5 up to the next posedge.
module tb_pulse_sync_sched;

  logic       src_clk;
  logic       src_rst;
  logic       en;
  logic [3:0] req;
  logic [3:0] ovf_clr;
  logic       s_pluse;
  logic [1:0] s_id;
  logic       pend_any;
  logic [3:0] ovf;

  typedef struct {
    int cyc;
    int id;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   origin = 0;

  pulse_sync_sched #(.N_REQ(4), .GAP(6), .CNT_W(4), .IDW(2)) dut (
    .src_clk  (src_clk),
    .src_rst  (src_rst),
    .en       (en),
    .req      (req),
    .ovf_clr  (ovf_clr),
    .s_pluse  (s_pluse),
    .s_id     (s_id),
    .pend_any (pend_any),
    .ovf      (ovf)
  );

  initial begin
    src_clk = 1'b0;
    forever #5 src_clk = ~src_clk;
  end

  function automatic int cyc_now();
    longint t;
    t = longint'($time);
    return int'((t - 5) / 10);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, actual, required, cyc_now());
    end
  endtask

  task automatic waitCycle(input int rel);
    while (cyc_now() < origin + rel) @(posedge src_clk);
    #1;
  endtask

  task automatic applyStimulus(input int rel, input logic [3:0] r, input logic e, input logic [3:0] c);
    waitCycle(rel);
    req     = r;
    en      = e;
    ovf_clr = c;
  endtask

  task automatic sampleAt(input int rel);
    waitCycle(rel);
    @(negedge src_clk);
  endtask

  task automatic expectPulse(input int rel, input int id);
    exp_t e;
    e.cyc = origin + rel;
    e.id  = id;
    exp_q.push_back(e);
  endtask

  task automatic newOrigin();
    origin = cyc_now();
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge src_clk);
      n++;
    end
    checkOutput({"drain_", name}, exp_q.size(), 0);
    exp_q.delete();
    repeat (10) @(posedge src_clk);
    @(negedge src_clk);
    checkOutput({"idle_pend_", name}, pend_any, 1'b0);
  endtask

  // Monitor: every observed pulse must match the head of the scoreboard.
  always @(negedge src_clk) begin
    if (!src_rst && s_pluse) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_pulse actual=id%0d required=none (cycle %0d)", s_id, cyc_now());
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("pulse_cycle", cyc_now(), mon_e.cyc);
        checkOutput("pulse_id", s_id, mon_e.id);
      end
    end
  end

  initial begin
    src_rst = 1'b1;
    en      = 1'b1;
    req     = '0;
    ovf_clr = '0;
    repeat (3) @(posedge src_clk);
    @(negedge src_clk);
    checkOutput("rst_s_pluse", s_pluse, 1'b0);
    checkOutput("rst_s_id", s_id, 2'd0);
    checkOutput("rst_pend_any", pend_any, 1'b0);
    checkOutput("rst_ovf", ovf, 4'h0);
    @(posedge src_clk);
    #1;
    src_rst = 1'b0;

    // All requesters at once: ids 0..3 spaced GAP apart.
    $display("[TB] all requesters");
    newOrigin();
    expectPulse(12, 0);
    expectPulse(18, 1);
    expectPulse(24, 2);
    expectPulse(30, 3);
    applyStimulus(10, 4'b1111, 1'b1, 4'b0000);
    applyStimulus(11, 4'b0000, 1'b1, 4'b0000);
    sampleAt(30);
    checkOutput("all_pend30", pend_any, 1'b1);
    sampleAt(31);
    checkOutput("all_pend31", pend_any, 1'b0);
    drain("all", 40);

    // Single event on requester 2.
    $display("[TB] single event");
    newOrigin();
    expectPulse(12, 2);
    applyStimulus(10, 4'b0100, 1'b1, 4'b0000);
    applyStimulus(11, 4'b0000, 1'b1, 4'b0000);
    sampleAt(11);
    checkOutput("single_pend11", pend_any, 1'b0);
    sampleAt(12);
    checkOutput("single_pend12", pend_any, 1'b1);
    sampleAt(13);
    checkOutput("single_pend13", pend_any, 1'b0);
    checkOutput("single_sid13", s_id, 2'd2);
    drain("single", 30);

    // Burst on requester 1 overlapping its own grant.
    $display("[TB] burst");
    newOrigin();
    expectPulse(12, 1);
    expectPulse(18, 1);
    expectPulse(24, 1);
    applyStimulus(10, 4'b0010, 1'b1, 4'b0000);
    applyStimulus(13, 4'b0000, 1'b1, 4'b0000);
    sampleAt(24);
    checkOutput("burst_pend24", pend_any, 1'b1);
    sampleAt(25);
    checkOutput("burst_pend25", pend_any, 1'b0);
    drain("burst", 40);

    // Saturation with en low, overflow set-wins-over-clear, then drain 15 pulses.
    $display("[TB] saturation");
    newOrigin();
    applyStimulus(5, 4'b0000, 1'b0, 4'b0000);
    applyStimulus(10, 4'b1000, 1'b0, 4'b0000);
    sampleAt(25);
    checkOutput("sat_ovf25", ovf, 4'h0);
    applyStimulus(26, 4'b1000, 1'b0, 4'b1000);
    checkOutput("sat_ovf26", ovf, 4'h8);
    applyStimulus(27, 4'b0000, 1'b0, 4'b1000);
    sampleAt(27);
    checkOutput("sat_ovf27_setwins", ovf, 4'h8);
    for (int k = 0; k < 15; k++) begin
      expectPulse(29 + 6 * k, 3);
    end
    applyStimulus(28, 4'b0000, 1'b1, 4'b0000);
    sampleAt(28);
    checkOutput("sat_ovf28_cleared", ovf, 4'h0);
    checkOutput("sat_pend28", pend_any, 1'b1);
    drain("sat", 200);

    // Reset in the middle of HOLD drops the queued second pulse.
    $display("[TB] reset mid-hold");
    newOrigin();
    expectPulse(12, 2);
    applyStimulus(10, 4'b0100, 1'b1, 4'b0000);
    applyStimulus(12, 4'b0000, 1'b1, 4'b0000);
    sampleAt(13);
    checkOutput("rmid_pend13", pend_any, 1'b1);
    waitCycle(14);
    src_rst = 1'b1;
    sampleAt(14);
    checkOutput("rmid_s_pluse", s_pluse, 1'b0);
    checkOutput("rmid_s_id", s_id, 2'd0);
    checkOutput("rmid_pend", pend_any, 1'b0);
    waitCycle(20);
    src_rst = 1'b0;
    expectPulse(32, 1);
    applyStimulus(30, 4'b0010, 1'b1, 4'b0000);
    applyStimulus(31, 4'b0000, 1'b1, 4'b0000);
    sampleAt(31);
    checkOutput("rmid_sid31", s_id, 2'd0);
    drain("rmid", 40);

    // Requester 0 returns while requester 1 is still waiting.
    $display("[TB] requester 0 re-request");
    newOrigin();
    expectPulse(12, 0);
`ifdef PSCHED_PRIO0_EN
    expectPulse(18, 0);
    expectPulse(24, 1);
`else
    expectPulse(18, 1);
    expectPulse(24, 0);
`endif
    applyStimulus(10, 4'b0011, 1'b1, 4'b0000);
    applyStimulus(11, 4'b0000, 1'b1, 4'b0000);
    applyStimulus(16, 4'b0001, 1'b1, 4'b0000);
    applyStimulus(17, 4'b0000, 1'b1, 4'b0000);
    drain("prio", 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
